kypd_emulator: RTL
==================

# kypd_emulator

Keypad emulator for the 4x4 matrix keypad interface. It watches the active-low column drive from the keypad scanner and pulls the matching active-low row line low, so a chosen key appears pressed. Each request is accepted over a valid/ready handshake and held pressed for a fixed number of clocks, followed by a fixed release gap. It replaces the physical keypad in simulation and board self-test.

## Interface
- HOLD_CYCLES, 64: clocks the key is held pressed; legal range 1..65535.
- GAP_CYCLES, 64: clocks of forced release after each press; legal range 1..65535.
- clk  in  1: sole clock; all state changes on its rising edge.
- reset  in  1: synchronous, active-high.
- col  in  4: column drive from the scanner; a 0 bit means that column is being scanned.
- row  out  4: row return to the scanner; 0 = pulled low (key contact), 1 = released.
- req_valid  in  1: a key request is present.
- req_key  in  4: key code 0x0..0xF.
- req_ready  out  1: the emulator can accept a request.
- abort  in  1: end the current press early.
- busy  out  1: state is not IDLE.
- done  out  1: one-cycle pulse when a press/gap sequence completes.
- press_count  out  8: number of completed sequences; wraps.

## Operation
- Key map (code -> column, row):
  - 1 -> c0,r0; 2 -> c1,r0; 3 -> c2,r0.
  - 4 -> c0,r1; 5 -> c1,r1; 6 -> c2,r1.
  - 7 -> c0,r2; 8 -> c1,r2; 9 -> c2,r2.
  - 0 -> c0,r3; F -> c1,r3; E -> c2,r3.
  - A -> c3,r0; B -> c3,r1; C -> c3,r2; D -> c3,r3.
- States:
  - IDLE: waiting for a request.
  - PRESS: key held.
  - GAP: forced release.
- Transitions:
  - IDLE -> PRESS on req_valid && req_ready. The key position is latched and the counter is loaded with HOLD_CYCLES-1.
  - PRESS -> GAP when the counter reaches 0, or when abort is high. The counter is loaded with GAP_CYCLES-1.
  - GAP -> IDLE when the counter reaches 0. done pulses and press_count increments. Aborted presses also count.
- Row output (combinational from col and registered state):
  - row[r] = 0 only if state is PRESS, r equals the latched row, and col[latched column] = 0.
  - Otherwise row[r] = 1.
  - Other low columns never affect row. Several low col bits give the same result as one.
- Request side:
  - req_ready = (state == IDLE) && !reset.
  - req_key is ignored when no handshake occurs.
  - abort is ignored in IDLE and GAP.
- Reset state:
  - state IDLE, row 4'hF, done 0, press_count 0, busy 0.
  - Latched key 0, held but unused.

## Timing
- Handshake sampled at rising edge k.
- PRESS occupies cycles k+1 .. k+HOLD_CYCLES.
- GAP occupies cycles k+HOLD_CYCLES+1 .. k+HOLD_CYCLES+GAP_CYCLES.
- IDLE is reached at cycle k+HOLD_CYCLES+GAP_CYCLES+1. done=1 and req_ready=1 in that same cycle, so back-to-back requests are spaced exactly HOLD_CYCLES+GAP_CYCLES+1 clocks.
- press_count shows the incremented value in the cycle after done.
- abort sampled high at edge j during PRESS: row releases from cycle j+1. GAP then lasts exactly GAP_CYCLES cycles.
- abort arriving on the same edge as natural PRESS expiry: a single transition to GAP, no extra effect.
- col -> row is combinational, zero clock latency. The scanner samples row in the same cycle it drives col.
- Reset mid-PRESS or mid-GAP:
  - Next cycle: state IDLE, row 4'hF, no done pulse, press_count 0.
  - A request present during the reset cycle is not accepted.
- press_count wraps 255 -> 0.

## Structure
- Shared package kypd_pkg holds:
  - State enum (IDLE, PRESS, GAP).
  - Key position struct {col_idx[1:0], row_idx[1:0]}.
  - Function key_to_pos implementing the key map above. The scanner-side decode and the bench use the same map.
- One sub-module, kypd_hold_timer, a 16-bit loadable down-counter:
  - load, load_val, zero outputs.
  - Used for both the PRESS and GAP durations.
- Top level contains the FSM, the key latch, the row decode, and press_count.

## Test plan
- Reset values: hold reset 3 cycles with col toggling → row=4'hF, req_ready=0, busy=0, press_count=0. The cycle after release → req_ready=1.
- Single press, HOLD_CYCLES=4, GAP_CYCLES=2:
  - Request key 5, then drive col=4'b1101 → row=4'b1101 for cycles 1..4 exactly.
  - col=4'b1110 → row=4'hF.
  - done at cycle 7; press_count=1 at cycle 8.
- Key D with col sweeping 1110/1101/1011/0111 → row=4'b0111 only while col=0111. col=4'b0000 → row=4'b0111.
- abort at PRESS cycle 2 → row=4'hF from cycle 3, done exactly GAP_CYCLES+1 cycles after abort, press_count increments.
- Back-to-back: req_valid held high with keys 1 then E → second handshake exactly HOLD_CYCLES+GAP_CYCLES+1 clocks after the first. Key E asserts row=4'b0111 only on col[2]=0.
- Reset at PRESS cycle 2 → row=4'hF and state IDLE the next cycle, no done. 256 completed presses → press_count=0.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared types and key map for the 4x4 keypad emulator.
package kypd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] col_idx;
        logic [1:0] row_idx;
    } key_pos_t;

    function automatic key_pos_t key_to_pos(input logic [3:0] key);
        key_pos_t p;
        unique case (key)
            4'h1: p = '{col_idx: 2'd0, row_idx: 2'd0};
            4'h2: p = '{col_idx: 2'd1, row_idx: 2'd0};
            4'h3: p = '{col_idx: 2'd2, row_idx: 2'd0};
            4'h4: p = '{col_idx: 2'd0, row_idx: 2'd1};
            4'h5: p = '{col_idx: 2'd1, row_idx: 2'd1};
            4'h6: p = '{col_idx: 2'd2, row_idx: 2'd1};
            4'h7: p = '{col_idx: 2'd0, row_idx: 2'd2};
            4'h8: p = '{col_idx: 2'd1, row_idx: 2'd2};
            4'h9: p = '{col_idx: 2'd2, row_idx: 2'd2};
            4'h0: p = '{col_idx: 2'd0, row_idx: 2'd3};
            4'hF: p = '{col_idx: 2'd1, row_idx: 2'd3};
            4'hE: p = '{col_idx: 2'd2, row_idx: 2'd3};
            4'hA: p = '{col_idx: 2'd3, row_idx: 2'd0};
            4'hB: p = '{col_idx: 2'd3, row_idx: 2'd1};
            4'hC: p = '{col_idx: 2'd3, row_idx: 2'd2};
            default: p = '{col_idx: 2'd3, row_idx: 2'd3};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/kypd_hold_timer.sv
// 16-bit loadable down-counter that parks at zero.
module kypd_hold_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        zero
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/kypd_emulator.sv
// Keypad emulator: holds one key pressed against the column scan,
// then forces a release gap before accepting the next request.
module kypd_emulator
    import kypd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 64,
    parameter int unsigned GAP_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] press_count
);

    localparam logic [15:0] HOLD_LD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    key_pos_t    key_q, key_d;
    logic        done_q, done_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tmr_load;
    logic [15:0] tmr_val;
    logic        tmr_zero;

    kypd_hold_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign req_ready = (state_q == IDLE) && !reset;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d  = PRESS;
                    key_d    = key_to_pos(req_key);
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            PRESS: begin
                if (tmr_zero || abort) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Count lags done by one cycle so it reflects completed sequences.
    assign cnt_d = cnt_q + {7'd0, done_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        row = 4'hF;
        if (state_q == PRESS && !col[key_q.col_idx]) begin
            row[key_q.row_idx] = 1'b0;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign press_count = cnt_q;

endmodule
